// File: rtl/timer_pkg.sv
// Shared widths, state encodings and mm:ss helper used by the countdown timer,
// the main controller and the setting counters.
package timer_pkg;

    localparam int SECS_PER_MIN = 60;
    localparam int MIN_W        = 7;
    localparam int SEC_W        = 6;
    localparam int TOT_W        = 13;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    // Total seconds from a minutes/seconds pair; the x60 is a constant multiply.
    function automatic logic [TOT_W-1:0] to_seconds(input logic [MIN_W-1:0] m,
                                                    input logic [SEC_W-1:0] s);
        return TOT_W'(m) * TOT_W'(SECS_PER_MIN) + TOT_W'(s);
    endfunction

endpackage

// File: rtl/countdown_timer_bar_thermometer.sv
// Combinational remaining/total thermometer compare for the LED bargraph.
module bar_thermometer
    import timer_pkg::*;
#(
    parameter int BAR_WIDTH = 8
) (
    input  logic [TOT_W-1:0]     remaining,
    input  logic [TOT_W-1:0]     total,
    input  logic                 active,
    output logic [BAR_WIDTH-1:0] bar
);

    localparam int PROD_W = 16;

    logic [PROD_W-1:0] rem_scaled;

    assign rem_scaled = PROD_W'(remaining) * PROD_W'(BAR_WIDTH);

    // Each LED compares against a constant multiple of total, avoiding a divider.
    generate
        for (genvar gi = 0; gi < BAR_WIDTH; gi++) begin : g_bit
            logic [PROD_W-1:0] threshold;
            assign threshold = PROD_W'(total) * PROD_W'(gi);
            assign bar[gi]   = active && (rem_scaled > threshold);
        end
    endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Main cooking countdown: loads mm:ss, decrements on enabled 1 Hz ticks,
// flags expiry and drives a remaining-time bargraph.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MINUTES = 99,
    parameter int BAR_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 enable,
    input  logic                 sec_tick,
    input  logic [MIN_W-1:0]     set_minutes,
    input  logic [SEC_W-1:0]     set_seconds,
    output logic [MIN_W-1:0]     minutes,
    output logic [SEC_W-1:0]     seconds,
    output logic                 timer_done,
    output logic [BAR_WIDTH-1:0] bargraph
);

    state_t                 state_reg, state_next;
    logic [MIN_W-1:0]       minutes_reg, minutes_next;
    logic [SEC_W-1:0]       seconds_reg, seconds_next;
    logic [TOT_W-1:0]       total_reg, total_next;
    logic [BAR_WIDTH-1:0]   bar_reg, bar_next;

    logic [MIN_W-1:0]       load_min;
    logic [SEC_W-1:0]       load_sec;
    logic [TOT_W-1:0]       load_total;
    logic [TOT_W-1:0]       remaining;
    logic                   count_step;

    assign load_min   = (set_minutes > MIN_W'(MAX_MINUTES)) ? MIN_W'(MAX_MINUTES) : set_minutes;
    assign load_sec   = (set_seconds > SEC_W'(SECS_PER_MIN - 1)) ? SEC_W'(SECS_PER_MIN - 1) : set_seconds;
    assign load_total = to_seconds(load_min, load_sec);
    assign remaining  = to_seconds(minutes_reg, seconds_reg);
    // A load in the same cycle swallows the tick.
    assign count_step = (state_reg == ST_ARMED) && enable && sec_tick && !load;

    always_comb begin
        state_next   = state_reg;
        minutes_next = minutes_reg;
        seconds_next = seconds_reg;
        total_next   = total_reg;
        if (load) begin
            minutes_next = load_min;
            seconds_next = load_sec;
            total_next   = load_total;
            state_next   = (load_total == '0) ? ST_EXPIRED : ST_ARMED;
        end else if (count_step) begin
            if (seconds_reg != '0) begin
                seconds_next = seconds_reg - SEC_W'(1);
            end else if (minutes_reg != '0) begin
                seconds_next = SEC_W'(SECS_PER_MIN - 1);
                minutes_next = minutes_reg - MIN_W'(1);
            end
            if (remaining <= TOT_W'(1)) begin
                state_next = ST_EXPIRED;
            end
        end
    end

    bar_thermometer #(
        .BAR_WIDTH (BAR_WIDTH)
    ) u_bar (
        .remaining (remaining),
        .total     (total_reg),
        .active    (state_reg != ST_IDLE),
        .bar       (bar_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            minutes_reg <= '0;
            seconds_reg <= '0;
            total_reg   <= '0;
            bar_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            minutes_reg <= minutes_next;
            seconds_reg <= seconds_next;
            total_reg   <= total_next;
            bar_reg     <= bar_next;
        end
    end

    assign minutes    = minutes_reg;
    assign seconds    = seconds_reg;
    assign timer_done = (state_reg == ST_EXPIRED);
    assign bargraph   = bar_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a seconds-count model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic       sec_tick = 1'b0;
    logic [6:0] set_minutes = '0;
    logic [5:0] set_seconds = '0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       timer_done;
    logic [7:0] bargraph;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model: remaining time as a plain seconds count; mode 0 idle, 1 armed, 2 expired.
    int         m_rem = 0;
    int         m_total = 0;
    int         m_mode = 0;
    logic [7:0] m_bar = '0;

    countdown_timer #(
        .MAX_MINUTES (99),
        .BAR_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .enable      (enable),
        .sec_tick    (sec_tick),
        .set_minutes (set_minutes),
        .set_seconds (set_seconds),
        .minutes     (minutes),
        .seconds     (seconds),
        .timer_done  (timer_done),
        .bargraph    (bargraph)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bar_of(input int rem, input int tot, input int mode);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (mode != 0) && (rem * 8 > k * tot);
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_total = 0; m_mode = 0; m_bar = '0;
        end else begin
            logic [7:0] nb;
            int cm, cs;
            nb = bar_of(m_rem, m_total, m_mode);
            if (load) begin
                cm = (int'(set_minutes) > 99) ? 99 : int'(set_minutes);
                cs = (int'(set_seconds) > 59) ? 59 : int'(set_seconds);
                m_rem = cm * 60 + cs;
                m_total = m_rem;
                m_mode = (m_rem == 0) ? 2 : 1;
            end else if (m_mode == 1 && enable && sec_tick && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end
            m_bar = nb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_minutes", int'(minutes), m_rem / 60);
            check("model_seconds", int'(seconds), m_rem % 60);
            check("model_done", int'(timer_done), (m_mode == 2) ? 1 : 0);
            check("model_bargraph", int'(bargraph), int'(m_bar));
        end
    end

    // One clock with the given inputs; returns at posedge+2 with strobes cleared.
    task automatic cyc(input logic l, input logic e, input logic t,
                       input logic [6:0] sm, input logic [5:0] ss);
        load = l; enable = e; sec_tick = t; set_minutes = sm; set_seconds = ss;
        @(posedge clk);
        #2;
        load = 1'b0; sec_tick = 1'b0;
        $display("cycle t=%0t load=%0b en=%0b tick=%0b -> %0d:%0d done=%0b bar=%h",
                 $time, l, e, t, minutes, seconds, timer_done, bargraph);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("reset_minutes", int'(minutes), 0);
        check("reset_seconds", int'(seconds), 0);
        check("reset_done", int'(timer_done), 0);
        check("reset_bar", int'(bargraph), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        // 0:05 countdown
        cyc(1, 1, 0, 7'd0, 6'd5);
        check("load5_seconds", int'(seconds), 5);
        check("load5_done", int'(timer_done), 0);
        cyc(0, 1, 0, 7'd0, 6'd0);
        check("load5_bar_full", int'(bargraph), 8'hFF);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 7'd0, 6'd0);
            check("count5_seconds", int'(seconds), 4 - i);
            check("count5_done", int'(timer_done), (i == 4) ? 1 : 0);
            if (i == 1) check("count5_bar_4of5", int'(bargraph), 8'h7F);
        end
        cyc(0, 1, 0, 7'd0, 6'd0);
        check("count5_bar_empty", int'(bargraph), 8'h00);

        // 2:00 borrow
        cyc(1, 1, 0, 7'd2, 6'd0);
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("borrow_minutes", int'(minutes), 1);
        check("borrow_seconds", int'(seconds), 59);
        cyc(0, 1, 0, 7'd0, 6'd0);
        check("borrow_bar", int'(bargraph), 8'hFF);

        // zero load
        cyc(1, 1, 0, 7'd0, 6'd0);
        check("zero_done", int'(timer_done), 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 7'd0, 6'd0);
        check("zero_hold_minutes", int'(minutes), 0);
        check("zero_hold_seconds", int'(seconds), 0);
        check("zero_bar", int'(bargraph), 8'h00);

        // enable low holds
        cyc(1, 0, 0, 7'd1, 6'd30);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 7'd0, 6'd0);
        check("hold_minutes", int'(minutes), 1);
        check("hold_seconds", int'(seconds), 30);
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("resume_seconds", int'(seconds), 29);

        // load beats tick, then reload from expired
        cyc(1, 1, 0, 7'd0, 6'd10);
        cyc(0, 1, 1, 7'd0, 6'd0);
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("pre_collide_seconds", int'(seconds), 8);
        cyc(1, 1, 1, 7'd0, 6'd20);
        check("collide_seconds", int'(seconds), 20);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, 7'd0, 6'd0);
        check("collide_expired", int'(timer_done), 1);
        cyc(1, 1, 0, 7'd0, 6'd20);
        check("reload_done_falls", int'(timer_done), 0);

        // clamping
        cyc(1, 1, 0, 7'd120, 6'd63);
        check("clamp_minutes", int'(minutes), 99);
        check("clamp_seconds", int'(seconds), 59);
        cyc(0, 1, 1, 7'd0, 6'd0);
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("clamp_bar", int'(bargraph), 8'hFF);
        check("clamp_count_seconds", int'(seconds), 57);

        // asynchronous reset mid-count
        #1 reset = 1'b1;
        #1;
        check("midreset_minutes", int'(minutes), 0);
        check("midreset_seconds", int'(seconds), 0);
        check("midreset_done", int'(timer_done), 0);
        check("midreset_bar", int'(bargraph), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("idle_after_reset_seconds", int'(seconds), 0);
        cyc(1, 1, 0, 7'd0, 6'd3);
        cyc(0, 1, 1, 7'd0, 6'd0);
        check("after_reset_count", int'(seconds), 2);
        cyc(0, 1, 0, 7'd0, 6'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
